// File: rtl/sort_seq.sv
// Handshaked odd-even transposition sorter: one compare-and-swap phase per clock.
// Optional SORT_EARLY_EXIT_EN: leave SORT after two consecutive swap-free phases.

module sort_seq_cas #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             desc_i,
  output logic             ooo_o
);
  // Strict compares: equal neighbours are never reported out of order.
  assign ooo_o = desc_i ? (a_i < b_i) : (a_i > b_i);
endmodule

module sort_seq #(
  parameter int NUM_VALS = 8,
  parameter int WIDTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_VALS*WIDTH-1:0] in_data,
  input  logic                      descend,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_VALS*WIDTH-1:0] out_data,
  output logic                      busy
);
  localparam int PW = $clog2(NUM_VALS) + 1;

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

  state_t                           state_q, state_d;
  // Ascending packed range puts element 0 in the MS slice.
  logic [0:NUM_VALS-1][WIDTH-1:0]   elems_q, elems_d;
  logic [PW-1:0]                    phase_q, phase_d;
  logic                             mode_q, mode_d;
  logic                             in_ready_q, in_ready_d;
  logic                             out_valid_q, out_valid_d;
  logic                             busy_q, busy_d;
  logic [NUM_VALS-2:0]              ooo, act, swp;
  logic                             last_phase, done_now;
`ifdef SORT_EARLY_EXIT_EN
  logic                             clean_q, clean_d;
  logic                             any_swap;
`endif

  for (genvar g = 0; g < NUM_VALS - 1; g++) begin : g_cas
    localparam logic ODD = 1'(g % 2);
    sort_seq_cas #(.WIDTH(WIDTH)) u_cas (
      .a_i    (elems_q[g]),
      .b_i    (elems_q[g+1]),
      .desc_i (mode_q),
      .ooo_o  (ooo[g])
    );
    // Pair (g,g+1) is live on even phases for even g, odd phases for odd g.
    assign act[g] = (phase_q[0] == ODD);
  end

  assign swp        = ooo & act;
  assign last_phase = (phase_q == PW'(NUM_VALS - 1));
`ifdef SORT_EARLY_EXIT_EN
  assign any_swap   = |swp;
`endif

  always_comb begin
    state_d     = state_q;
    elems_d     = elems_q;
    phase_d     = phase_q;
    mode_d      = mode_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done_now    = 1'b0;
`ifdef SORT_EARLY_EXIT_EN
    clean_d     = clean_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          elems_d    = in_data;
          mode_d     = descend;
          phase_d    = '0;
          state_d    = SORT;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
`ifdef SORT_EARLY_EXIT_EN
          clean_d    = 1'b0;
`endif
        end
      end
      SORT: begin
        for (int i = 0; i < NUM_VALS - 1; i++) begin
          if (swp[i]) begin
            elems_d[i]   = elems_q[i+1];
            elems_d[i+1] = elems_q[i];
          end
        end
        done_now = last_phase;
`ifdef SORT_EARLY_EXIT_EN
        // Two back-to-back clean phases cover both parities: array is sorted.
        done_now = done_now || (!any_swap && clean_q);
        clean_d  = !any_swap;
`endif
        if (done_now) begin
          state_d     = DONE;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      elems_q     <= '0;
      phase_q     <= '0;
      mode_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SORT_EARLY_EXIT_EN
      clean_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      elems_q     <= elems_d;
      phase_q     <= phase_d;
      mode_q      <= mode_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef SORT_EARLY_EXIT_EN
      clean_q     <= clean_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = elems_q;
endmodule

// File: tb/tb_sort_seq.sv
// Directed table-driven bench for sort_seq (NUM_VALS=8, WIDTH=4).
module tb_sort_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, descend, out_valid, out_ready, busy;
  logic [31:0] in_data, out_data;
  int          checks = 0;
  int          failures = 0;

  sort_seq #(.NUM_VALS(8), .WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .descend(descend), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] din;
    logic        desc;
    logic [31:0] exp;
    int          ee_lat;  // early-exit latency, 0 = anything up to 8
    logic        tog;     // scramble descend/in_data during SORT
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one vector, wait for the result; handshake it only when hs=1.
  task automatic run_vec(input vec_t v, input bit hs);
    int k, lat, bcnt;
    k = 0;
    while (!in_ready && k < 20) begin tick(); k++; end
    chk("accept_wait", 64'(k), 0);
    in_valid = 1'b1; in_data = v.din; descend = v.desc;
    tick();
    in_valid = 1'b0;
    lat = 0; bcnt = 0;
    while (!out_valid && lat < 20) begin
      if (busy) bcnt++;
      if (in_ready) chk("in_ready_sort", 64'(in_ready), 0);
      if (v.tog) begin descend = ~v.desc; in_data = ~v.din; end
      tick();
      lat++;
    end
`ifdef SORT_EARLY_EXIT_EN
    if (v.ee_lat != 0) chk("latency", 64'(lat), 64'(v.ee_lat));
    else               chk("latency_le8", 64'(lat <= 8), 1);
`else
    chk("latency", 64'(lat), 8);
`endif
    chk("busy_cycles", 64'(bcnt), 64'(lat));
    chk("out_data", 64'(out_data), 64'(v.exp));
    chk("busy_done", 64'(busy), 0);
    chk("in_ready_done", 64'(in_ready), 0);
    if (hs) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("out_valid_after_hs", 64'(out_valid), 0);
      chk("in_ready_after_hs", 64'(in_ready), 1);
    end
  endtask

  initial begin
    tbl[0] = '{32'h31415926, 1'b1, 32'h96543211, 0, 1'b0};
    tbl[1] = '{32'h31415926, 1'b0, 32'h11234569, 0, 1'b1};
    tbl[2] = '{32'h01234567, 1'b1, 32'h76543210, 0, 1'b0};
    tbl[3] = '{32'h55555555, 1'b0, 32'h55555555, 2, 1'b0};
    tbl[4] = '{32'h96543211, 1'b1, 32'h96543211, 2, 1'b0};
    tbl[5] = '{32'h96543211, 1'b0, 32'h11234569, 0, 1'b1};
    tbl[6] = '{32'hF0F0F0F0, 1'b0, 32'h0000FFFF, 0, 1'b0};
    tbl[7] = '{32'hFEDCBA98, 1'b0, 32'h89ABCDEF, 0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; descend = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_out_data", 64'(out_data), 0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_vec(tbl[i], 1'b1);

    // Stall in DONE with out_ready low; stray in_valid pulses must be ignored.
    run_vec(tbl[0], 1'b0);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'($urandom_range(0, 1)); in_data = $urandom; descend = 1'($urandom_range(0, 1));
      tick();
      chk("stall_out_valid", 64'(out_valid), 1);
      chk("stall_out_data", 64'(out_data), 64'(32'h96543211));
      chk("stall_in_ready", 64'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("stall_hs_in_ready", 64'(in_ready), 1);
    run_vec(tbl[7], 1'b1);

    // Reset during phase 3 discards the vector.
    in_valid = 1'b1; in_data = 32'h31415926; descend = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("mid_busy_pre", 64'(busy), 1);
    for (int c = 0; c < 3; c++) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 0);
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_in_ready", 64'(in_ready), 1);
    chk("mid_rst_out_data", 64'(out_data), 0);
    #3 rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    begin
      int vcnt;
      vcnt = 0;
      for (int c = 0; c < 12; c++) begin
        if (out_valid) vcnt++;
        tick();
      end
      chk("no_hs_after_rst", 64'(vcnt), 0);
    end
    out_ready = 1'b0;
    run_vec(tbl[1], 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
